// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the two-master DRAM arbiter: grant encodings,
// Wishbone field widths and the round-robin pick used when both masters request.
package wb_mem_arbiter_pkg;

   localparam logic [1:0] GNT_IDLE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 128;
   localparam int WB_SEL_W  = WB_DATA_W / 8;

   // On a tie, the master that did not win last time gets the bus.
   function automatic logic [1:0] rr_pick(input logic cyc0, input logic cyc1,
                                          input logic last_m1);
      logic [1:0] pick;
      pick = GNT_IDLE;
      if (cyc0 && cyc1) pick = last_m1 ? GNT_M0 : GNT_M1;
      else if (cyc0)    pick = GNT_M0;
      else if (cyc1)    pick = GNT_M1;
      return pick;
   endfunction

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Classic Wishbone bundle for one master<->slave link of the DRAM arbiter.
// Handshake: cyc frames a locked transfer; each cycle with stb=1 is one beat
// that completes on the cycle the slave returns ack or err.
interface wb_mem_arbiter_if
   import wb_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W
);
   localparam int SEL_W = DATA_W / 8;

   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] dat_w;
   logic [DATA_W-1:0] dat_r;
   logic              we;
   logic [SEL_W-1:0]  sel;
   logic              cyc;
   logic              stb;
   logic              ack;
   logic              err;

   modport master (output adr, dat_w, we, sel, cyc, stb, input dat_r, ack, err);
   modport slave  (input adr, dat_w, we, sel, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_mem_arbiter_watchdog.sv
// Ack watchdog: counts consecutive unanswered stb cycles and fires a single
// pulse on the TIMEOUT-th one, then starts over.
module wb_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic stb,
   input  logic ack,
   input  logic err,
   output logic timeout
);
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   logic [CNT_W-1:0] cnt;

   // A slave answer in the terminal cycle beats the watchdog.
   assign timeout = stb & ~ack & ~err & (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cnt <= '0;
      else if (!stb || ack || err || timeout) cnt <= '0;
      else                              cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin arbiter in front of the DDR3 controller user port,
// with bus lock per cyc and an ack watchdog that converts a hung access to err.
module wb_mem_arbiter
   import wb_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   wb_mem_arbiter_if.slave   m0,
   wb_mem_arbiter_if.slave   m1,
   wb_mem_arbiter_if.master  s,
   output logic [1:0]        grant_o,
   output logic              timeout_o
);
   logic [1:0] grant_q;
   logic       last_m1;
   logic [1:0] pick;
   logic       cyc_raw;
   logic       stb_raw;
   logic       fire;

   assign pick = rr_pick(m0.cyc, m1.cyc, last_m1);

   // Owners always return to IDLE before the other master can be granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q <= GNT_IDLE;
         last_m1 <= 1'b1;
      end else begin
         case (grant_q)
            GNT_IDLE: begin
               grant_q <= pick;
               if (pick != GNT_IDLE) last_m1 <= (pick == GNT_M1);
            end
            GNT_M0:  if (!m0.cyc) grant_q <= GNT_IDLE;
            GNT_M1:  if (!m1.cyc) grant_q <= GNT_IDLE;
            default: grant_q <= GNT_IDLE;
         endcase
      end
   end

   always_comb begin
      cyc_raw = 1'b0;
      stb_raw = 1'b0;
      s.adr   = '0;
      s.dat_w = '0;
      s.we    = 1'b0;
      s.sel   = '0;
      case (grant_q)
         GNT_M0: begin
            cyc_raw = m0.cyc;
            stb_raw = m0.stb;
            s.adr   = m0.adr;
            s.dat_w = m0.dat_w;
            s.we    = m0.we;
            s.sel   = m0.sel;
         end
         GNT_M1: begin
            cyc_raw = m1.cyc;
            stb_raw = m1.stb;
            s.adr   = m1.adr;
            s.dat_w = m1.dat_w;
            s.we    = m1.we;
            s.sel   = m1.sel;
         end
         default: ;
      endcase
   end

   wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .stb     (stb_raw),
      .ack     (s.ack),
      .err     (s.err),
      .timeout (fire)
   );

   // The aborted beat is dropped from the slave port in the cycle err is returned.
   assign s.cyc     = cyc_raw & ~fire;
   assign s.stb     = stb_raw & ~fire;
   assign m0.dat_r  = s.dat_r;
   assign m1.dat_r  = s.dat_r;
   assign m0.ack    = s.ack & grant_q[0];
   assign m1.ack    = s.ack & grant_q[1];
   assign m0.err    = (s.err | fire) & grant_q[0];
   assign m1.err    = (s.err | fire) & grant_q[1];
   assign grant_o   = grant_q;
   assign timeout_o = fire;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Randomized bench for wb_mem_arbiter against a transaction-level model of
// ownership, round-robin ties and the stb age watchdog (TIMEOUT=16).
module tb_wb_mem_arbiter;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant_o;
   logic       timeout_o;

   wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(128)) m0_bus ();
   wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(128)) m1_bus ();
   wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(128)) s_bus ();

   wb_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_bus),
      .m1        (m1_bus),
      .s         (s_bus),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   // model: owner 0=idle, 1=m0, 2=m1; age = stb cycles already waited unanswered
   int owner, last_win, age;
   bit fire;
   int n_timeouts = 0;
   int n_ack_wins = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit cyc_of(input int m);
      return (m == 1) ? m0_bus.cyc : (m == 2) ? m1_bus.cyc : 1'b0;
   endfunction

   function automatic bit stb_of(input int m);
      return (m == 1) ? m0_bus.stb : (m == 2) ? m1_bus.stb : 1'b0;
   endfunction

   task automatic model_reset();
      owner = 0; last_win = 2; age = 0; fire = 0;
   endtask

   task automatic compare();
      bit pend;
      logic [31:0]  e_adr;
      logic [127:0] e_dat;
      logic [15:0]  e_sel;
      logic         e_we;
      pend  = (owner != 0) && stb_of(owner);
      fire  = pend && !s_bus.ack && !s_bus.err && (age + 1 == TIMEOUT);
      if (fire) n_timeouts++;
      if (pend && s_bus.ack && (age + 1 == TIMEOUT)) n_ack_wins++;
      e_adr = (owner == 1) ? m0_bus.adr   : (owner == 2) ? m1_bus.adr   : '0;
      e_dat = (owner == 1) ? m0_bus.dat_w : (owner == 2) ? m1_bus.dat_w : '0;
      e_sel = (owner == 1) ? m0_bus.sel   : (owner == 2) ? m1_bus.sel   : '0;
      e_we  = (owner == 1) ? m0_bus.we    : (owner == 2) ? m1_bus.we    : 1'b0;
      check("grant",   grant_o, (owner == 0) ? 2'b00 : 2'(1 << (owner - 1)));
      check("s_cyc",   s_bus.cyc, cyc_of(owner) && !fire);
      check("s_stb",   s_bus.stb, pend && !fire);
      check("s_adr",   s_bus.adr, e_adr);
      check("s_dat",   s_bus.dat_w, e_dat);
      check("s_sel",   s_bus.sel, e_sel);
      check("s_we",    s_bus.we, e_we);
      check("m0_ack",  m0_bus.ack, s_bus.ack && owner == 1);
      check("m1_ack",  m1_bus.ack, s_bus.ack && owner == 2);
      check("m0_err",  m0_bus.err, (s_bus.err || fire) && owner == 1);
      check("m1_err",  m1_bus.err, (s_bus.err || fire) && owner == 2);
      check("timeout", timeout_o, fire);
      check("m0_dat",  m0_bus.dat_r, s_bus.dat_r);
      check("m1_dat",  m1_bus.dat_r, s_bus.dat_r);
   endtask

   task automatic model_edge();
      bit pend;
      pend = (owner != 0) && stb_of(owner);
      if (pend && !s_bus.ack && !s_bus.err && !fire) age++;
      else age = 0;
      if (owner == 0) begin
         if (m0_bus.cyc && m1_bus.cyc) owner = (last_win == 1) ? 2 : 1;
         else if (m0_bus.cyc)          owner = 1;
         else if (m1_bus.cyc)          owner = 2;
         if (owner != 0) last_win = owner;
      end else if (!cyc_of(owner)) begin
         owner = 0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive_master(input int mode, input int idx);
      bit c, st, drop;
      c    = (idx == 0) ? m0_bus.cyc : m1_bus.cyc;
      drop = (mode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      if (c) c = !drop;
      else   c = ($urandom_range(0, 3) == 0);
      st = c && ((mode != 0) || ($urandom_range(0, 3) != 0));
      if (idx == 0) begin
         m0_bus.cyc = c; m0_bus.stb = st; m0_bus.we = 1'($urandom);
         m0_bus.adr = $urandom; m0_bus.sel = 16'($urandom);
         m0_bus.dat_w = {$urandom, $urandom, $urandom, $urandom};
      end else begin
         m1_bus.cyc = c; m1_bus.stb = st; m1_bus.we = 1'($urandom);
         m1_bus.adr = $urandom; m1_bus.sel = 16'($urandom);
         m1_bus.dat_w = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   // mode 0: random acks/errs; 1: slave silent; 2: ack exactly on the last allowed cycle
   task automatic drive_random(input int mode);
      drive_master(mode, 0);
      drive_master(mode, 1);
      s_bus.dat_r = {$urandom, $urandom, $urandom, $urandom};
      case (mode)
         0:       s_bus.ack = ($urandom_range(0, 2) == 0);
         1:       s_bus.ack = 1'b0;
         default: s_bus.ack = (age == TIMEOUT - 1);
      endcase
      s_bus.err = (mode == 0) && ($urandom_range(0, 19) == 0);
   endtask

   task automatic clear_inputs();
      m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.adr = '0; m0_bus.sel = '0; m0_bus.dat_w = '0;
      m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.adr = '0; m1_bus.sel = '0; m1_bus.dat_w = '0;
      s_bus.ack = 0; s_bus.err = 0; s_bus.dat_r = '0;
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", grant_o, 2'b00);
      check("rst_s_cyc", s_bus.cyc, 1'b0);
      check("rst_s_stb", s_bus.stb, 1'b0);
      check("rst_timeout", timeout_o, 1'b0);
      rst = 1'b0;

      // simultaneous first request: m0 must win, then m1 after an idle gap
      m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h100; m0_bus.sel = 16'hFFFF; m0_bus.we = 1;
      m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = 32'h200; m1_bus.sel = 16'h00FF;
      step();
      check("tie_first_m0", grant_o, 2'b01);
      step(); step();
      s_bus.ack = 1;
      step();
      s_bus.ack = 0; m0_bus.cyc = 0; m0_bus.stb = 0;
      step();
      check("gap_idle", grant_o, 2'b00);
      step();
      check("then_m1", grant_o, 2'b10);
      m1_bus.cyc = 0; m1_bus.stb = 0;
      step(); step();

      for (int i = 0; i < 600; i++) begin drive_random(0); step(); end
      for (int i = 0; i < 300; i++) begin drive_random(1); step(); end
      for (int i = 0; i < 300; i++) begin drive_random(2); step(); end
      for (int i = 0; i < 300; i++) begin drive_random(0); step(); end

      // hold until m1 owns the bus, then reset between edges
      guard = 0;
      while (owner != 2 && guard < 500) begin drive_random(0); step(); guard++; end
      check("reach_own1", owner == 2, 1'b1);
      m1_bus.cyc = 1; m1_bus.stb = 1; s_bus.ack = 1; s_bus.err = 0;
      #1;
      check("pre_rst_m1_ack", m1_bus.ack, (owner == 2) ? 1'b1 : 1'b0);
      #1 rst = 1'b1;
      #1;
      check("arst_grant", grant_o, 2'b00);
      check("arst_s_cyc", s_bus.cyc, 1'b0);
      check("arst_s_stb", s_bus.stb, 1'b0);
      check("arst_m1_ack", m1_bus.ack, 1'b0);
      rst = 1'b0;
      model_reset();
      clear_inputs();
      m0_bus.cyc = 1; m0_bus.stb = 1;
      step();
      check("post_rst_m0", grant_o, 2'b01);
      m0_bus.cyc = 0; m0_bus.stb = 0;
      for (int i = 0; i < 200; i++) begin drive_random(0); step(); end

      check("cov_timeouts", n_timeouts > 0, 1'b1);
      check("cov_ack_wins", n_ack_wins > 0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
